// File: rtl/lbp_pkg.sv
// -----------------------------------------------------------------------------
// lbp_pkg
// Shared definitions for the streaming Local Binary Pattern engine:
//   - FSM state encoding
//   - border policy constants
//   - bit position of each neighbour inside the 8-bit LBP code
//   - coordinate clamp helper used to address neighbours at the image edge
// -----------------------------------------------------------------------------
package lbp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic BORDER_ZERO = 1'b0;
    localparam logic BORDER_REP  = 1'b1;

    // Bit index of each neighbour in the code (T=top row, B=bottom row).
    localparam int NB_TL = 0;
    localparam int NB_T  = 1;
    localparam int NB_TR = 2;
    localparam int NB_L  = 3;
    localparam int NB_R  = 4;
    localparam int NB_BL = 5;
    localparam int NB_B  = 6;
    localparam int NB_BR = 7;

    // Step a coordinate by sel-1 (sel: 0 -> v-1, 1 -> v, 2 -> v+1),
    // clamped to [0, hi].
    function automatic int unsigned clamp_step(int unsigned v, logic [1:0] sel,
                                               int unsigned hi);
        int unsigned r;
        r = v;
        if (sel == 2'd0) begin
            if (v != 0) r = v - 1;
        end else if (sel == 2'd2) begin
            if (v < hi) r = v + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lbp_stream_if.sv
// -----------------------------------------------------------------------------
// lbp_stream_if
// Host / memory side signals of the LBP engine.
//   gray_ready, border_mode : host control (start, border policy)
//   gray_addr, gray_req     : gray memory read request
//   gray_data               : read data, valid one cycle after gray_req
//   lbp_addr, lbp_valid,
//   lbp_data                : LBP memory write strobe
//   finish                  : sticky completion flag
// modport master : the LBP engine
// modport slave  : host plus gray/LBP memories
// -----------------------------------------------------------------------------
interface lbp_stream_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
);
    logic              gray_ready;
    logic              border_mode;
    logic [ADDR_W-1:0] gray_addr;
    logic              gray_req;
    logic [PIX_W-1:0]  gray_data;
    logic [ADDR_W-1:0] lbp_addr;
    logic              lbp_valid;
    logic [7:0]        lbp_data;
    logic              finish;

    modport master (
        input  gray_ready, border_mode, gray_data,
        output gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data, finish
    );

    modport slave (
        output gray_ready, border_mode, gray_data,
        input  gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data, finish
    );
endinterface

// File: rtl/lbp_code.sv
// -----------------------------------------------------------------------------
// lbp_code
// Combinational LBP code of a 3x3 window.
//   win  : window, win[row][col], row 0 = y-1, col 0 = x-1, centre win[1][1]
//   code : bit k set when neighbour k >= centre (unsigned compare)
// -----------------------------------------------------------------------------
module lbp_code
    import lbp_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [2:0][2:0][PIX_W-1:0] win,
    output logic [7:0]                 code
);
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path can leave it unassigned and infer a latch.
        code        = '0;
        code[NB_TL] = (win[0][0] >= win[1][1]);
        code[NB_T]  = (win[0][1] >= win[1][1]);
        code[NB_TR] = (win[0][2] >= win[1][1]);
        code[NB_L]  = (win[1][0] >= win[1][1]);
        code[NB_R]  = (win[1][2] >= win[1][1]);
        code[NB_BL] = (win[2][0] >= win[1][1]);
        code[NB_B]  = (win[2][1] >= win[1][1]);
        code[NB_BR] = (win[2][2] >= win[1][1]);
    end
endmodule

// File: rtl/lbp_stream.sv
// -----------------------------------------------------------------------------
// lbp_stream
// Streams a grayscale image out of gray memory and writes one LBP code per
// pixel, row-major, into LBP memory. The 3x3 window slides along a row so an
// interior pixel costs three reads (5 cycles) once the window is primed; a
// fresh window costs nine reads (11 cycles).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : lbp_stream_if.master (host control, gray read port,
//                LBP write port, finish)
// -----------------------------------------------------------------------------
module lbp_stream
    import lbp_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
) (
    input  logic         clk,
    input  logic         reset,
    lbp_stream_if.master bus
);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] X_MAX    = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_MAX    = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t state, state_nx;

    logic                       mode;       // border policy latched at start
    logic [ADDR_W-1:0]          x, y;
    logic [ADDR_W-1:0]          row_base;   // y*IMG_W, kept incrementally
    logic                       win_valid;
    logic [3:0]                 fcnt;       // FETCH cycle counter
    logic                       cap_en;     // a read issued last cycle
    logic [1:0]                 cap_row, cap_col;
    logic [2:0][2:0][PIX_W-1:0] win;
    logic [7:0]                 code;

    logic                       skip, row_end, last_pix, next_skip;
    logic [ADDR_W-1:0]          x_nx, y_nx;
    logic [3:0]                 n_rd;
    logic                       issue;
    logic [1:0]                 iss_row, iss_col;
    logic [ADDR_W-1:0]          nb_x, nb_row_base;

    function automatic logic on_edge(logic [ADDR_W-1:0] px, logic [ADDR_W-1:0] py);
        return (px == '0) || (px == X_MAX) || (py == '0) || (py == Y_MAX);
    endfunction

    lbp_code #(.PIX_W(PIX_W)) u_code (
        .win  (win),
        .code (code)
    );

    // Scan position and the read currently being issued.
    always_comb begin
        row_end   = (x == X_MAX);
        last_pix  = row_end && (y == Y_MAX);
        x_nx      = row_end ? '0 : x + ONE;
        y_nx      = row_end ? y + ONE : y;
        skip      = (mode == BORDER_ZERO) && on_edge(x, y);
        next_skip = (mode == BORDER_ZERO) && on_edge(x_nx, y_nx);

        n_rd  = win_valid ? 4'd3 : 4'd9;
        issue = (state == FETCH) && !skip && (fcnt < n_rd);

        // Columns are read left, centre, right; each one top to bottom.
        iss_col = 2'd2;
        iss_row = fcnt[1:0];
        if (!win_valid) begin
            if (fcnt >= 4'd6) begin
                iss_col = 2'd2;
                iss_row = 2'(fcnt - 4'd6);
            end else if (fcnt >= 4'd3) begin
                iss_col = 2'd1;
                iss_row = 2'(fcnt - 4'd3);
            end else begin
                iss_col = 2'd0;
                iss_row = fcnt[1:0];
            end
        end

        nb_x = ADDR_W'(clamp_step(32'(x), iss_col, IMG_W - 1));
        nb_row_base = row_base;
        if (iss_row == 2'd0 && y != '0)    nb_row_base = row_base - ROW_STEP;
        if (iss_row == 2'd2 && y != Y_MAX) nb_row_base = row_base + ROW_STEP;

        bus.gray_req  = issue;
        bus.gray_addr = issue ? nb_row_base + nb_x : '0;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (bus.gray_ready) state_nx = FETCH;
            // The first pixel always enters FETCH; a zero-policy border pixel
            // leaves it at once without issuing a read.
            FETCH: if (skip || fcnt == n_rd) state_nx = WRITE;
            WRITE: begin
                if (last_pix)       state_nx = DONE;
                else if (next_skip) state_nx = WRITE;
                else                state_nx = FETCH;
            end
            DONE:  state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode          <= BORDER_ZERO;
            x             <= '0;
            y             <= '0;
            row_base      <= '0;
            win_valid     <= 1'b0;
            fcnt          <= '0;
            cap_en        <= 1'b0;
            cap_row       <= '0;
            cap_col       <= '0;
            bus.lbp_addr  <= '0;
            bus.lbp_valid <= 1'b0;
            bus.lbp_data  <= '0;
            bus.finish    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the values from before this edge.
            cap_en        <= issue;
            cap_row       <= iss_row;
            cap_col       <= iss_col;
            bus.lbp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.gray_ready) mode <= bus.border_mode;
                end
                FETCH: begin
                    fcnt <= (state_nx == WRITE) ? 4'd0 : fcnt + 4'd1;
                end
                WRITE: begin
                    bus.lbp_valid <= 1'b1;
                    bus.lbp_addr  <= row_base + x;
                    bus.lbp_data  <= skip ? 8'h00 : code;
                    // A skipped pixel or a new row leaves nothing to slide.
                    win_valid     <= !skip && !row_end;
                    if (!last_pix) begin
                        x <= x_nx;
                        y <= y_nx;
                        if (row_end) row_base <= row_base + ROW_STEP;
                    end
                end
                DONE: begin
                    bus.finish <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the window is pure datapath and is always fully loaded before it
    // is used, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == FETCH && fcnt == 4'd0 && win_valid && !skip) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
        end
        if (cap_en) win[cap_row][cap_col] <= bus.gray_data;
    end

endmodule

// File: tb/tb_lbp_stream.sv
// -----------------------------------------------------------------------------
// tb_lbp_stream
// Self-checking bench for lbp_stream on a small non-square image. A gray
// memory with one-cycle read latency feeds the engine; every write, read
// and the finish flag are logged on the falling edge and compared with a
// reference computed directly from the LBP definition.
// -----------------------------------------------------------------------------
module tb_lbp_stream;
    import lbp_pkg::*;

    localparam int W    = 7;
    localparam int H    = 5;
    localparam int PW   = 8;
    localparam int AW   = 6;
    localparam int NPIX = W * H;

    // Neighbour offsets in code bit order.
    localparam int DX [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    localparam int DY [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

    logic clk = 1'b0;
    logic reset;

    lbp_stream_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();

    lbp_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [PW-1:0] mem [NPIX];
    always @(posedge clk) begin
        if (bus.gray_req) bus.gray_data <= mem[bus.gray_addr];
    end

    int cyc = 0;
    int wr_addr [$];
    int wr_data [$];
    int wr_cyc  [$];
    int reads, bad_reads, fin_cyc;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.lbp_valid) begin
            wr_addr.push_back(int'(bus.lbp_addr));
            wr_data.push_back(int'(bus.lbp_data));
            wr_cyc.push_back(cyc);
        end
        if (bus.gray_req) begin
            reads++;
            if (int'(bus.gray_addr) >= NPIX) bad_reads++;
        end
        if (bus.finish && fin_cyc < 0) fin_cyc = cyc;
    end

    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        reads     = 0;
        bad_reads = 0;
        fin_cyc   = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.gray_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        clear_log();
    endtask

    // kind 0: flat 50, 1: pixel = address, 2: random, 3: random in 0..3
    task automatic fill(int kind);
        for (int i = 0; i < NPIX; i++) begin
            case (kind)
                0:       mem[i] = 8'd50;
                1:       mem[i] = 8'(i);
                2:       mem[i] = 8'($urandom_range(0, 255));
                default: mem[i] = 8'($urandom_range(0, 3));
            endcase
        end
    endtask

    function automatic int clampi(int v, int hi);
        return (v < 0) ? 0 : (v > hi) ? hi : v;
    endfunction

    function automatic int model_code(int px, int py, bit m);
        int code = 0;
        if (m == 1'b0 && (px == 0 || px == W - 1 || py == 0 || py == H - 1))
            return 0;
        for (int k = 0; k < 8; k++) begin
            int nx = clampi(px + DX[k], W - 1);
            int ny = clampi(py + DY[k], H - 1);
            if (mem[ny * W + nx] >= mem[py * W + px]) code |= (1 << k);
        end
        return code;
    endfunction

    task automatic start(bit m);
        bus.border_mode = m;
        bus.gray_ready  = 1'b1;
        tick(1);
        bus.gray_ready  = 1'b0;
        bus.border_mode = ~m;   // must have been latched already
    endtask

    task automatic wait_finish(string tag, bit toggle);
        for (int i = 0; i < 3000 && !bus.finish; i++) begin
            if (toggle) bus.gray_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        bus.gray_ready = 1'b0;
        check({tag, "_finish_reached"}, int'(bus.finish), 1);
    endtask

    task automatic verify(bit m, string tag);
        int valid = 0;
        int exp_reads = 0;
        int cost [NPIX];
        // Cycles between write strobes: a skipped pixel is one WRITE; a
        // fetched pixel is N reads + one idle FETCH cycle + WRITE.
        for (int i = 0; i < NPIX; i++) begin
            int px = i % W;
            int py = i / W;
            if (m == 1'b0 && (px == 0 || px == W - 1 || py == 0 || py == H - 1)) begin
                cost[i] = 1;
                valid   = 0;
            end else begin
                cost[i]    = (valid != 0 ? 3 : 9) + 2;
                exp_reads += (valid != 0) ? 3 : 9;
                valid      = 1;
            end
            if (px == W - 1) valid = 0;
        end
        check({tag, "_write_count"}, wr_data.size(), NPIX);
        check({tag, "_read_count"}, reads, exp_reads);
        check({tag, "_reads_in_range"}, bad_reads, 0);
        if (wr_data.size() == NPIX) begin
            for (int i = 0; i < NPIX; i++) begin
                check($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
                check($sformatf("%s_code%0d", tag, i), wr_data[i],
                      model_code(i % W, i / W, m));
                if (i > 0)
                    check($sformatf("%s_gap%0d", tag, i), wr_cyc[i] - wr_cyc[i-1], cost[i]);
            end
            check({tag, "_finish_cycle"}, fin_cyc, wr_cyc[NPIX-1] + 1);
        end
    endtask

    task automatic run_image(int kind, bit m, bit toggle, string tag);
        do_reset();
        fill(kind);
        start(m);
        wait_finish(tag, toggle);
        tick(2);
        verify(m, tag);
    endtask

    initial begin
        reset           = 1'b1;
        bus.gray_ready  = 1'b0;
        bus.border_mode = 1'b0;
        clear_log();
        tick(2);
        check("rst_gray_req",  int'(bus.gray_req), 0);
        check("rst_gray_addr", int'(bus.gray_addr), 0);
        check("rst_lbp_valid", int'(bus.lbp_valid), 0);
        check("rst_lbp_addr",  int'(bus.lbp_addr), 0);
        check("rst_lbp_data",  int'(bus.lbp_data), 0);
        check("rst_finish",    int'(bus.finish), 0);

        // No start while gray_ready stays low.
        reset = 1'b0;
        tick(20);
        check("idle_reads",  reads, 0);
        check("idle_writes", wr_data.size(), 0);

        // Flat image, zero border: interior all-ones, border zero.
        run_image(0, BORDER_ZERO, 1'b0, "flat_zero");
        if (wr_data.size() == NPIX) begin
            check("flat_zero_interior", wr_data[W + 1], 'hFF);
            check("flat_zero_border",   wr_data[W], 'h00);
        end

        // Ramp image, zero border: only the lower/right neighbours are >=.
        run_image(1, BORDER_ZERO, 1'b0, "ramp_zero");
        if (wr_data.size() == NPIX)
            check("ramp_zero_interior", wr_data[2 * W + 2], 'hF0);

        // Ramp image, replicate border.
        run_image(1, BORDER_REP, 1'b0, "ramp_rep");
        if (wr_data.size() == NPIX) begin
            check("ramp_rep_first", wr_data[0], 'hFF);
            check("ramp_rep_last",  wr_data[NPIX - 1], 'hD0);
        end

        // Random images, gray_ready toggling mid-run.
        run_image(2, BORDER_ZERO, 1'b1, "rand_zero");
        run_image(3, BORDER_REP,  1'b1, "rand_rep_low");
        run_image(2, BORDER_REP,  1'b0, "rand_rep");

        // Finish is sticky and nothing else happens in DONE.
        clear_log();
        tick(6);
        check("done_finish_held", int'(bus.finish), 1);
        check("done_no_writes",   wr_data.size(), 0);
        check("done_no_reads",    reads, 0);

        // Reset in the middle of a FETCH.
        do_reset();
        fill(2);
        start(BORDER_REP);
        for (int i = 0; i < 2000 && !(wr_data.size() >= 10 && bus.gray_req); i++) tick(1);
        check("abort_in_fetch", int'(bus.gray_req), 1);
        #2 reset = 1'b1;
        #1;
        check("abort_gray_req",  int'(bus.gray_req), 0);
        check("abort_gray_addr", int'(bus.gray_addr), 0);
        check("abort_lbp_valid", int'(bus.lbp_valid), 0);
        check("abort_lbp_addr",  int'(bus.lbp_addr), 0);
        check("abort_lbp_data",  int'(bus.lbp_data), 0);
        check("abort_finish",    int'(bus.finish), 0);
        tick(2);
        reset = 1'b0;
        clear_log();
        tick(10);
        check("abort_no_resume_reads",  reads, 0);
        check("abort_no_resume_writes", wr_data.size(), 0);
        start(BORDER_REP);
        wait_finish("restart", 1'b0);
        tick(2);
        verify(BORDER_REP, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
